// File: rtl/key_pulser_pkg.sv
// key_pulser_pkg -- shared definitions for the key pulser and the stopwatch
// it drives.
//   DB_LEN_DEF  : default debounce length (stable synchronized samples)
//   NUM_KEYS    : number of push-buttons handled
//   KEY_*       : bit positions of each button in key_n / held
//   sw_state_e  : stopwatch state encoding, shared so both sides agree
//   cnt_width() : width of a debounce counter able to hold DB_LEN-1
package key_pulser_pkg;

    localparam int DB_LEN_DEF = 4;
    localparam int NUM_KEYS   = 3;

    localparam int KEY_START = 0;
    localparam int KEY_STOP  = 1;
    localparam int KEY_LAP   = 2;

    typedef enum logic [1:0] {
        SW_IDLE  = 2'b00,
        SW_COUNT = 2'b01,
        SW_LAP   = 2'b10,
        SW_STOP  = 2'b11
    } sw_state_e;

    // Debounced level of one key; the encoding matches the raw active-low pin.
    typedef enum logic {
        DEB_PRESSED  = 1'b0,
        DEB_RELEASED = 1'b1
    } deb_state_e;

    // Counter only needs to reach DB_LEN-1, so $clog2(DB_LEN) bits suffice
    // for every legal DB_LEN (2..65535).
    function automatic int cnt_width(input int db_len);
        return (db_len <= 2) ? 1 : $clog2(db_len);
    endfunction

endpackage

// File: rtl/key_pulser_if.sv
// key_pulser_if -- button inputs and stopwatch command outputs of key_pulser.
//   key_n : raw active-low push-buttons (bit0 start, bit1 stop, bit2 lap/clear)
//   sw1   : one-cycle start pulse
//   sw2   : one-cycle stop pulse
//   sw3   : one-cycle lap/clear pulse
//   held  : debounced pressed level per key, active-high
// master = the side owning the buttons / consuming pulses, slave = key_pulser.
interface key_pulser_if;

    logic [key_pulser_pkg::NUM_KEYS-1:0] key_n;
    logic                                sw1;
    logic                                sw2;
    logic                                sw3;
    logic [key_pulser_pkg::NUM_KEYS-1:0] held;

    modport master (
        output key_n,
        input  sw1,
        input  sw2,
        input  sw3,
        input  held
    );

    modport slave (
        input  key_n,
        output sw1,
        output sw2,
        output sw3,
        output held
    );

endinterface

// File: rtl/key_debounce.sv
// key_debounce -- one push-button: two-flop synchronizer, then a debouncer
// that accepts a level change only after DB_LEN consecutive synchronized
// samples disagree with the current debounced level.
//   clk   : rising-edge clock
//   rst   : synchronous active-low reset
//   key_n : raw asynchronous button, active-low
//   st    : debounced level, 1 = released
//   press : high in the cycle whose edge moves st from released to pressed
//           (combinational; the caller registers it on that same edge)
module key_debounce
    import key_pulser_pkg::*;
#(
    parameter int DB_LEN = DB_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic st,
    output logic press
);

    localparam int              CW      = cnt_width(DB_LEN);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DB_LEN - 1);

    logic            s1, s2;
    deb_state_e      state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            state <= DEB_RELEASED;
            cnt   <= '0;
        end else begin
            s1    <= key_n;
            s2    <= s1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt tracks how many consecutive earlier samples already disagreed; the
    // sample that finds cnt at its maximum is the DB_LEN-th and commits.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press     = 1'b0;
        if (s2 == logic'(state)) begin
            cnt_nxt = '0;
        end else if (cnt < CNT_MAX) begin
            cnt_nxt = cnt + 1'b1;
        end else begin
            state_nxt = deb_state_e'(s2);
            cnt_nxt   = '0;
            press     = (state == DEB_RELEASED);
        end
    end

    assign st = logic'(state);

endmodule

// File: rtl/key_pulser.sv
// key_pulser -- turns three bouncing push-buttons into clean one-cycle
// stopwatch commands.
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   kp  : key_pulser_if.slave (key_n in; sw1/sw2/sw3/held out)
// Each key is debounced independently; press events are arbitrated
// stop > start > lap and registered, so at most one pulse is high per cycle.
// An event that loses arbitration is dropped, not deferred.
module key_pulser
    import key_pulser_pkg::*;
#(
    parameter int DB_LEN = DB_LEN_DEF
) (
    input  logic          clk,
    input  logic          rst,
    key_pulser_if.slave   kp
);

    logic [NUM_KEYS-1:0] st;
    logic [NUM_KEYS-1:0] press;
    logic                sw1_q, sw2_q, sw3_q;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DB_LEN (DB_LEN)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .key_n (kp.key_n[i]),
            .st    (st[i]),
            .press (press[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sw1_q <= 1'b0;
            sw2_q <= 1'b0;
            sw3_q <= 1'b0;
        end else begin
            sw2_q <= press[KEY_STOP];
            sw1_q <= press[KEY_START] & ~press[KEY_STOP];
            sw3_q <= press[KEY_LAP] & ~press[KEY_STOP] & ~press[KEY_START];
        end
    end

    assign kp.sw1  = sw1_q;
    assign kp.sw2  = sw2_q;
    assign kp.sw3  = sw3_q;
    assign kp.held = ~st;

endmodule

// File: tb/tb_key_pulser.sv
// tb_key_pulser -- self-checking bench for key_pulser (DB_LEN = 4).
// A window-based reference model predicts pulses and held levels; a small
// stopwatch model is driven by the DUT pulses for the command sequence test.
module tb_key_pulser;
    import key_pulser_pkg::*;

    localparam int DB = 4;

    logic clk;
    logic rst;
    key_pulser_if kp();

    key_pulser #(.DB_LEN(DB)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] sw;
    assign sw = {kp.sw3, kp.sw2, kp.sw1};

    // ---------------- reference model ----------------
    // A key's debounced level flips once the last DB synchronized samples all
    // disagree with it; samples reach the debouncer two edges after the pin.
    logic [2:0] m_p1, m_p2, m_st, exp_sw;
    logic [2:0] hist [DB-1];
    logic [2:0] all0, all1, m_press;

    always_comb begin
        all0 = ~m_p2;
        all1 = m_p2;
        for (int j = 0; j < DB - 1; j++) begin
            all0 &= ~hist[j];
            all1 &= hist[j];
        end
        m_press = all0 & m_st;
    end

    always @(posedge clk) begin
        if (!rst) begin
            m_p1   <= '1;
            m_p2   <= '1;
            m_st   <= '1;
            exp_sw <= '0;
            for (int j = 0; j < DB - 1; j++) hist[j] <= '1;
        end else begin
            m_p1    <= kp.key_n;
            m_p2    <= m_p1;
            hist[0] <= m_p2;
            for (int j = 1; j < DB - 1; j++) hist[j] <= hist[j-1];
            m_st    <= (m_st & ~all0) | all1;
            exp_sw  <= m_press[1] ? 3'b010 :
                       m_press[0] ? 3'b001 :
                       m_press[2] ? 3'b100 : 3'b000;
        end
    end

    // ---------------- stopwatch model ----------------
    sw_state_e sw_st, sw_nxt;
    int enter_cnt [4] = '{default: 0};

    always_comb begin
        sw_nxt = sw_st;
        case (sw_st)
            SW_IDLE:  if (kp.sw1) sw_nxt = SW_COUNT;
            SW_COUNT: if (kp.sw2) sw_nxt = SW_STOP; else if (kp.sw3) sw_nxt = SW_LAP;
            SW_LAP:   if (kp.sw2) sw_nxt = SW_STOP; else if (kp.sw1) sw_nxt = SW_COUNT;
            SW_STOP:  if (kp.sw3) sw_nxt = SW_IDLE; else if (kp.sw1) sw_nxt = SW_COUNT;
            default:  ;
        endcase
    end

    always @(posedge clk) begin
        if (!rst) begin
            sw_st <= SW_IDLE;
        end else begin
            sw_st <= sw_nxt;
            if (sw_nxt != sw_st) enter_cnt[int'(sw_nxt)] <= enter_cnt[int'(sw_nxt)] + 1;
        end
    end

    // Drive keys, then advance to the next falling edge (one rising edge passes).
    task automatic tick(input logic [2:0] k);
        kp.key_n = k;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(3'b000);
            checks++;
            if (sw !== 3'b000 || kp.held !== 3'b000) begin
                errors++;
                $display("FAIL reset_state cyc=%0d sw=%b held=%b want sw=000 held=000", i, sw, kp.held);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(3'b111);
            checks++;
            if (sw !== exp_sw || kp.held !== ~m_st) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d sw=%b held=%b want sw=%b held=%b", i, sw, kp.held, exp_sw, ~m_st);
            end
        end
    endtask

    task automatic test_single_press();
        int n1;
        logic [2:0] want;
        n1 = 0;
        for (int i = 0; i < 20; i++) begin
            tick(3'b110);
            want = (i == 5) ? 3'b001 : 3'b000;
            if (kp.sw1) n1++;
            checks++;
            if (sw !== exp_sw || kp.held !== ~m_st) begin
                errors++;
                $display("FAIL single_model cyc=%0d sw=%b held=%b want sw=%b held=%b", i, sw, kp.held, exp_sw, ~m_st);
            end
            checks++;
            if (sw !== want || kp.held[0] !== (i >= 5)) begin
                errors++;
                $display("FAIL single_timing cyc=%0d sw=%b held0=%b want sw=%b held0=%b", i, sw, kp.held[0], want, (i >= 5));
            end
        end
        checks++;
        if (n1 !== 1) begin
            errors++;
            $display("FAIL single_count sw1 pulses=%0d want 1", n1);
        end
        for (int i = 0; i < 10; i++) begin
            tick(3'b111);
            checks++;
            if (sw !== exp_sw || kp.held !== ~m_st) begin
                errors++;
                $display("FAIL single_release cyc=%0d sw=%b held=%b want sw=%b held=%b", i, sw, kp.held, exp_sw, ~m_st);
            end
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 13; i++) begin
            tick((i < 3) ? 3'b101 : 3'b111);
            checks++;
            if (sw !== 3'b000 || kp.held !== 3'b000 || sw !== exp_sw) begin
                errors++;
                $display("FAIL glitch cyc=%0d sw=%b held=%b want sw=000 held=000 (model sw=%b)", i, sw, kp.held, exp_sw);
            end
        end
    endtask

    task automatic test_simultaneous();
        int n1, n2, n3;
        n1 = 0; n2 = 0; n3 = 0;
        for (int i = 0; i < 20; i++) begin
            tick(3'b100);
            n1 += int'(kp.sw1);
            n2 += int'(kp.sw2);
            n3 += int'(kp.sw3);
            checks++;
            if (sw !== exp_sw || kp.held !== ~m_st) begin
                errors++;
                $display("FAIL simul_model cyc=%0d sw=%b held=%b want sw=%b held=%b", i, sw, kp.held, exp_sw, ~m_st);
            end
        end
        checks++;
        if (n2 !== 1 || n1 !== 0 || n3 !== 0) begin
            errors++;
            $display("FAIL simul_priority sw1=%0d sw2=%0d sw3=%0d want 0/1/0", n1, n2, n3);
        end
        checks++;
        if (kp.held !== 3'b011) begin
            errors++;
            $display("FAIL simul_held held=%b want 011", kp.held);
        end
        for (int i = 0; i < 10; i++) tick(3'b111);
    endtask

    task automatic test_bounce();
        int n3;
        n3 = 0;
        for (int i = 0; i < 10; i++) begin
            tick((i % 2 == 0) ? 3'b011 : 3'b111);
            checks++;
            if (sw !== 3'b000 || sw !== exp_sw) begin
                errors++;
                $display("FAIL bounce_quiet cyc=%0d sw=%b want 000 (model %b)", i, sw, exp_sw);
            end
        end
        for (int j = 0; j < 15; j++) begin
            tick(3'b011);
            if (kp.sw3) n3++;
            checks++;
            if (sw !== exp_sw || kp.sw3 !== (j == 5)) begin
                errors++;
                $display("FAIL bounce_pulse cyc=%0d sw=%b want sw3=%b (model %b)", j, sw, (j == 5), exp_sw);
            end
        end
        checks++;
        if (n3 !== 1) begin
            errors++;
            $display("FAIL bounce_count sw3 pulses=%0d want 1", n3);
        end
        for (int i = 0; i < 10; i++) tick(3'b111);
    endtask

    task automatic test_reset_mid_press();
        int n;
        for (int i = 0; i < 20; i++) begin
            tick(3'b110);
            checks++;
            if (sw !== exp_sw || kp.held !== ~m_st) begin
                errors++;
                $display("FAIL midrst_pre cyc=%0d sw=%b held=%b want sw=%b held=%b", i, sw, kp.held, exp_sw, ~m_st);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(3'b110);
            checks++;
            if (sw !== 3'b000 || kp.held !== 3'b000) begin
                errors++;
                $display("FAIL midrst_hold cyc=%0d sw=%b held=%b want 000/000", i, sw, kp.held);
            end
        end
        rst = 1'b1;
        n = 0;
        for (int j = 0; j < 10; j++) begin
            tick(3'b110);
            n += int'(kp.sw1);
            checks++;
            if (sw !== exp_sw || kp.sw1 !== (j == 5)) begin
                errors++;
                $display("FAIL midrst_fresh cyc=%0d sw=%b want sw1=%b (model %b)", j, sw, (j == 5), exp_sw);
            end
        end
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL midrst_count sw1 pulses=%0d want 1", n);
        end
        for (int i = 0; i < 10; i++) tick(3'b111);
        // Stop key partway through its count, then reset: the change is lost.
        for (int i = 0; i < 4; i++) tick(3'b101);
        rst = 1'b0;
        tick(3'b111);
        rst = 1'b1;
        n = 0;
        for (int j = 0; j < 10; j++) begin
            tick(3'b111);
            n += int'(kp.sw2);
        end
        checks++;
        if (n !== 0 || kp.held !== 3'b000) begin
            errors++;
            $display("FAIL midrst_discard sw2 pulses=%0d held=%b want 0/000", n, kp.held);
        end
    endtask

    task automatic test_random();
        int cyc, len;
        logic [2:0] k;
        cyc = 0;
        while (cyc < 400) begin
            k   = 3'($urandom);
            len = $urandom_range(1, 9);
            for (int j = 0; j < len; j++) begin
                tick(k);
                cyc++;
                checks++;
                if (sw !== exp_sw || kp.held !== ~m_st) begin
                    errors++;
                    $display("FAIL random_model cyc=%0d key_n=%b sw=%b held=%b want sw=%b held=%b", cyc, k, sw, kp.held, exp_sw, ~m_st);
                end
                checks++;
                if ($countones(sw) > 1) begin
                    errors++;
                    $display("FAIL random_onehot cyc=%0d sw=%b want at most one bit", cyc, sw);
                end
            end
        end
        for (int i = 0; i < 10; i++) tick(3'b111);
    endtask

    task automatic test_stopwatch();
        logic [2:0] seq [4]       = '{3'b110, 3'b011, 3'b101, 3'b011};
        sw_state_e  want_st [4]   = '{SW_COUNT, SW_LAP, SW_STOP, SW_IDLE};
        int         base [4];
        rst = 1'b0;
        tick(3'b111);
        tick(3'b111);
        rst = 1'b1;
        for (int s = 0; s < 4; s++) base[s] = enter_cnt[s];
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 20; i++) begin
                tick((i < 10) ? seq[p] : 3'b111);
                checks++;
                if (sw !== exp_sw || kp.held !== ~m_st) begin
                    errors++;
                    $display("FAIL sw_model step=%0d cyc=%0d sw=%b held=%b want sw=%b held=%b", p, i, sw, kp.held, exp_sw, ~m_st);
                end
            end
            checks++;
            if (sw_st !== want_st[p]) begin
                errors++;
                $display("FAIL sw_state step=%0d state=%b want %b", p, sw_st, want_st[p]);
            end
        end
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (enter_cnt[s] - base[s] !== 1) begin
                errors++;
                $display("FAIL sw_entries state=%0d entered=%0d want 1", s, enter_cnt[s] - base[s]);
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        kp.key_n = 3'b111;
        @(negedge clk);
        test_reset();
        test_single_press();
        test_glitch();
        test_simultaneous();
        test_bounce();
        test_reset_mid_press();
        test_random();
        test_stopwatch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
